// File: rtl/universal_shift_register.sv
`default_nettype none
// ============================================================================
// Module   : universal_shift_register
// Brief    : WIDTH-bit register with hold / shift right / shift left / load.
//            Define USR_ROTATE_EN to turn the shifts into rotates.
// Revision : 1.0 - initial release
// ============================================================================
module universal_shift_register #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] out
);

  localparam logic [1:0] c_SEL_HOLD = 2'b00;
  localparam logic [1:0] c_SEL_SHR  = 2'b01;
  localparam logic [1:0] c_SEL_SHL  = 2'b10;
  localparam logic [1:0] c_SEL_LOAD = 2'b11;

  logic [WIDTH-1:0] r_q;
  logic             w_fill_msb;
  logic             w_fill_lsb;

`ifdef USR_ROTATE_EN
  // Rotate: the bit falling off one end re-enters at the other.
  assign w_fill_msb = r_q[0];
  assign w_fill_lsb = r_q[WIDTH-1];
`else
  assign w_fill_msb = in[WIDTH-1];
  assign w_fill_lsb = in[0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else begin
      case (sel)
        c_SEL_HOLD: r_q <= r_q;
        c_SEL_SHR:  r_q <= {w_fill_msb, r_q[WIDTH-1:1]};
        c_SEL_SHL:  r_q <= {r_q[WIDTH-2:0], w_fill_lsb};
        c_SEL_LOAD: r_q <= in;
        default:    r_q <= r_q;
      endcase
    end
  end

  assign out = r_q;

endmodule
`default_nettype wire

// File: tb/tb_universal_shift_register.sv
`default_nettype none
// ============================================================================
// Module   : tb_universal_shift_register
// Brief    : Directed scoreboard bench for universal_shift_register (WIDTH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_universal_shift_register;

  logic       clk;
  logic       rst;
  logic [3:0] din;
  logic [1:0] sel;
  logic [3:0] dout;

  logic [3:0] exp_q[$];
  string      tag_q[$];
  int         total;
  int         bad;

  universal_shift_register #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .in  (din),
    .sel (sel),
    .out (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic r, input logic [1:0] s, input logic [3:0] d,
                      input logic [3:0] e, input string tag);
    logic [3:0] exp_v;
    string      tag_v;
    @(negedge clk);
    rst = r;
    sel = s;
    din = d;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    exp_v = exp_q.pop_front();
    tag_v = tag_q.pop_front();
    total++;
    assert (dout === exp_v) else begin
      bad++;
      $error("FAIL %s: out=%b expected=%b", tag_v, dout, exp_v);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    sel   = 2'b00;
    din   = 4'b0000;

    // Reset with arbitrary mode/data
    step(1'b1, 2'b11, 4'b0110, 4'b0000, "reset");

    // Load then hold
    step(1'b0, 2'b11, 4'b1011, 4'b1011, "load");
    step(1'b0, 2'b00, 4'b0100, 4'b1011, "hold1");
    step(1'b0, 2'b00, 4'b0100, 4'b1011, "hold2");

`ifdef USR_ROTATE_EN
    step(1'b0, 2'b11, 4'b1001, 4'b1001, "rot_load");
    step(1'b0, 2'b01, 4'b0000, 4'b1100, "rotr");
    step(1'b0, 2'b10, 4'b0000, 4'b1001, "rotl1");
    step(1'b0, 2'b10, 4'b0000, 4'b0011, "rotl2");
    step(1'b0, 2'b01, 4'b1111, 4'b1001, "rotr_in_ignored");
    step(1'b0, 2'b10, 4'b1111, 4'b0011, "rotl_in_ignored");
`else
    // Sequential modes, one per edge
    step(1'b0, 2'b11, 4'b1011, 4'b1011, "seq_load");
    step(1'b0, 2'b01, 4'b1011, 4'b1101, "seq_shr");
    step(1'b0, 2'b10, 4'b1011, 4'b1011, "seq_shl");
    step(1'b0, 2'b00, 4'b1011, 4'b1011, "seq_hold");

    // Zero fill, shift right
    step(1'b0, 2'b11, 4'b1111, 4'b1111, "zr_load");
    step(1'b0, 2'b01, 4'b0000, 4'b0111, "zr1");
    step(1'b0, 2'b01, 4'b0000, 4'b0011, "zr2");
    step(1'b0, 2'b01, 4'b0000, 4'b0001, "zr3");
    step(1'b0, 2'b01, 4'b0000, 4'b0000, "zr4");

    // Zero fill, shift left
    step(1'b0, 2'b11, 4'b1111, 4'b1111, "zl_load");
    step(1'b0, 2'b10, 4'b0000, 4'b1110, "zl1");
    step(1'b0, 2'b10, 4'b0000, 4'b1100, "zl2");
    step(1'b0, 2'b10, 4'b0000, 4'b1000, "zl3");
    step(1'b0, 2'b10, 4'b0000, 4'b0000, "zl4");

    // One fill: MSB fill from in[3], LSB fill from in[0] only
    step(1'b0, 2'b01, 4'b1000, 4'b1000, "fill_msb");
    step(1'b0, 2'b10, 4'b0001, 4'b0001, "fill_lsb");
`endif

    // Reset priority over load, then hold keeps zero
    step(1'b0, 2'b11, 4'b1011, 4'b1011, "rp_load");
    step(1'b1, 2'b11, 4'b1111, 4'b0000, "rp_reset");
    step(1'b0, 2'b00, 4'b1111, 4'b0000, "rp_hold");
    step(1'b0, 2'b11, 4'b0101, 4'b0101, "rp_resume");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: out=%b expected=completion", dout);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
